dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Initiator-side controller for the byte-addressed data memory. It is driven by the MEM stage of the pipeline.
- Accepts one load/store request at a time through a valid/ready handshake.
- Drives the memory's per-byte write-enable, address and shared bidirectional data bus.
- Returns sign/zero-extended load data or a store acknowledgement through a valid/ready response channel, and flags misaligned or illegal accesses without touching memory.

Parameters:
- WAIT_CYCLES, 0: extra cycles the address is held stable before load data is captured (0..15).
- CHECK_ALIGN, 1: 1 = misaligned half/word accesses return an error; 0 = passed through unaligned.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  16  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal request
- dm_w_en  out  4  per-byte write enable to memory; 0000 = read
- dm_address  out  16  memory byte address
- dm_data  inout  32  shared data bus; driven only while dm_w_en != 0, else high-Z

Behaviour:
- Reset (asynchronous, immediate) forces:
  - state IDLE
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - dm_w_en=0000, dm_address=0, dm_data released to high-Z.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch we/funct3/addr/wdata.
  - If the request is illegal, go to RESP with err=1; no memory cycle occurs.
  - Otherwise go to ACCESS.
- Illegal request is any of:
  - funct3 in {011, 110, 111}
  - store with funct3[2]=1
  - CHECK_ALIGN=1 and a half access with addr[0]=1
  - CHECK_ALIGN=1 and a word access with addr[1:0]!=00
- req_ready=0 in every state except IDLE. There is no overlap of consecutive requests.
- ACCESS, store (lasts exactly one cycle):
  - dm_address=latched addr.
  - dm_w_en = 0001 (B), 0011 (H) or 1111 (W).
  - dm_data=latched wdata.
  - Memory commits at the edge ending ACCESS; next state RESP.
- ACCESS, load:
  - dm_w_en=0000, dm_address=latched addr.
  - If WAIT_CYCLES=0, capture dm_data at the edge ending ACCESS and go to RESP; otherwise go to WAIT.
- WAIT (loads only):
  - A 4-bit counter counts WAIT_CYCLES cycles with the address held.
  - Capture dm_data at the edge ending the last WAIT cycle, then go to RESP.
- Load extraction (byte 0 = mem[addr]):
  - B: sign-extend bits 7:0.
  - BU: zero-extend bits 7:0.
  - H: sign-extend bits 15:0.
  - HU: zero-extend bits 15:0.
  - W: bits 31:0 unchanged.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready=1 at an edge, then go to IDLE.
  - dm_w_en=0000 and dm_address holds its last value.
- dm_w_en is nonzero only in ACCESS for stores. dm_data is never driven while dm_w_en=0000, so there is no bus contention with memory read drive.
- Latency, request-accept edge to rsp_valid high, with rsp_ready held at 1:
  - store: 2 cycles
  - load: 2+WAIT_CYCLES cycles
  - error: 1 cycle
- Back-to-back throughput is 1 request per 3 cycles at best.
- Reset mid-operation: all state is abandoned and dm_w_en drops combinationally with rst_n. A store whose ACCESS cycle is cut by reset before its edge must not write memory. Any pending response is discarded.
- rsp_ready held high while in IDLE/ACCESS/WAIT has no effect.

Test Plan:
- SW 0xDEADBEEF @0x0100, then LW @0x0100 -> dm_w_en=1111 for exactly one cycle; load returns 0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
- SB 0x00000080 @0x0103, then LB @0x0103 -> 0xFFFFFF80; LBU @0x0103 -> 0x00000080; bytes 0x0100..0x0102 unchanged (LW -> 0x80ADBEEF).
- LH @0x0101 with CHECK_ALIGN=1 -> rsp_err=1, rsp_rdata=0, dm_w_en stays 0000, response 1 cycle after accept; funct3=011 load -> err=1.
- LW with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready=0 until the cycle after handshake.
- WAIT_CYCLES=2: LW -> rsp_valid 4 cycles after accept; dm_address stable across ACCESS and WAIT.
- Assert rst_n=0 during the ACCESS cycle of SW 0x12345678 @0x0200 -> dm_w_en=0000 and dm_data high-Z immediately; a later LW @0x0200 returns the prior contents.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: initiator-side controller for the byte-addressed data memory,
// driven by the MEM stage. It takes one load or store at a time, runs the memory
// cycle and returns the result on a valid/ready response channel.
//
// Parameters
//   WAIT_CYCLES  extra cycles the address is held before load data is captured (0..15)
//   CHECK_ALIGN  1 = misaligned half/word accesses are rejected with rsp_err
//
// Ports
//   clk, rst_n                     rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake; req_ready only in IDLE
//   req_we, req_funct3             1 = store; RISC-V width code (B/H/W/BU/HU)
//   req_addr, req_wdata            byte address, LSB-aligned store data
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             extended load data (0 for stores/errors), error flag
//   dm_w_en, dm_address, dm_data   memory byte enables, address, shared data bus
module dm_access_ctrl #(
  parameter int WAIT_CYCLES = 0,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  dm_w_en,
  output logic [15:0] dm_address,
  inout  wire  [31:0] dm_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Counter value on the final WAIT cycle; unused when WAIT_CYCLES is 0.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        illegal;
  logic        capture;
  logic [31:0] load_ext;

  // Request legality is judged on the live request inputs at the accept edge.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = req_we;  // no unsigned stores
      default:                illegal = 1'b0;
    endcase
    if (CHECK_ALIGN != 0) begin
      if (req_funct3[1:0] == 2'b01 && req_addr[0])          illegal = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) illegal = 1'b1;
    end
  end

  // Byte 0 of the bus is mem[addr], so extraction always starts at bit 0.
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{dm_data[7]}}, dm_data[7:0]};
      3'b100:  load_ext = {24'b0, dm_data[7:0]};
      3'b001:  load_ext = {{16{dm_data[15]}}, dm_data[15:0]};
      3'b101:  load_ext = {16'b0, dm_data[15:0]};
      default: load_ext = dm_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = illegal ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else if (WAIT_CYCLES == 0) begin
          state_d = ST_RESP;
          capture = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
          capture = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 16'h0000;
      wdata_q  <= 32'h0000_0000;
      cnt_q    <= 4'h0;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        cnt_q    <= 4'h0;
        rdata_q  <= 32'h0000_0000;
        err_q    <= illegal;
        // Rejected requests never reach memory, so the bus address keeps its old value.
        if (!illegal) addr_q <= req_addr;
      end
      if (state_q == ST_WAIT) cnt_q <= cnt_q + 4'h1;
      if (capture) rdata_q <= load_ext;
    end
  end

  // Only legal stores reach ACCESS with we_q set, so funct3_q[1:0] is 00/01/10.
  // Deriving the enables from the asynchronously reset state makes them drop
  // the moment rst_n falls, cancelling a store mid-cycle.
  always_comb begin
    dm_w_en = 4'b0000;
    if (state_q == ST_ACCESS && we_q) begin
      case (funct3_q[1:0])
        2'b00:   dm_w_en = 4'b0001;
        2'b01:   dm_w_en = 4'b0011;
        default: dm_w_en = 4'b1111;
      endcase
    end
  end

  // The bus is driven only together with a write enable, never while memory may drive.
  assign dm_data    = (dm_w_en != 4'b0000) ? wdata_q : 32'hzzzz_zzzz;
  assign dm_address = addr_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed bench for dm_access_ctrl. Instance "a" uses
// WAIT_CYCLES=0 with a read/write byte memory model; instance "b" uses
// WAIT_CYCLES=2 with a read-only memory. Expected responses go into a
// scoreboard queue when a request is issued and are popped at the handshake.
module tb_dm_access_ctrl;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;

  // Instance a
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_funct3;
  logic [15:0] a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [3:0]  a_dm_w_en;
  logic [15:0] a_dm_address;
  wire  [31:0] a_dm_data;

  // Instance b
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [15:0] b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [3:0]  b_dm_w_en;
  logic [15:0] b_dm_address;
  wire  [31:0] b_dm_data;

  logic [7:0] mem_a [0:65535];
  logic       a_mem_drive;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  dm_access_ctrl #(.WAIT_CYCLES(0), .CHECK_ALIGN(1)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_we     (a_req_we),
    .req_funct3 (a_req_funct3),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .rsp_valid  (a_rsp_valid),
    .rsp_ready  (a_rsp_ready),
    .rsp_rdata  (a_rsp_rdata),
    .rsp_err    (a_rsp_err),
    .dm_w_en    (a_dm_w_en),
    .dm_address (a_dm_address),
    .dm_data    (a_dm_data)
  );

  dm_access_ctrl #(.WAIT_CYCLES(2), .CHECK_ALIGN(1)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_we     (b_req_we),
    .req_funct3 (b_req_funct3),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (b_rsp_ready),
    .rsp_rdata  (b_rsp_rdata),
    .rsp_err    (b_rsp_err),
    .dm_w_en    (b_dm_w_en),
    .dm_address (b_dm_address),
    .dm_data    (b_dm_data)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {init_byte(16'(a + 16'd3)), init_byte(16'(a + 16'd2)),
            init_byte(16'(a + 16'd1)), init_byte(a)};
  endfunction

  // A released bus floats to all ones, so an undriven bus is observable.
  pullup (a_dm_data);

  assign a_dm_data = (a_mem_drive && a_dm_w_en == 4'b0000)
                   ? {mem_a[16'(a_dm_address + 16'd3)], mem_a[16'(a_dm_address + 16'd2)],
                      mem_a[16'(a_dm_address + 16'd1)], mem_a[a_dm_address]}
                   : 32'hzzzz_zzzz;

  assign b_dm_data = (b_dm_w_en == 4'b0000) ? init_word(b_dm_address) : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_dm_w_en[i]) mem_a[16'(a_dm_address + 16'(i))] <= a_dm_data[8*i +: 8];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance a, starting 1 time unit after an edge in IDLE.
  task automatic run_a(input string tag, input logic we, input logic [2:0] f3,
                       input logic [15:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_wen, input int exp_lat, input int hold);
    int          lat;
    int          wen_cycles;
    logic [31:0] held_rd;
    logic        held_err;
    exp_t        e;
    check({tag, ".req_ready_idle"}, 32'(a_req_ready), 32'd1);
    a_req_valid  = 1'b1;
    a_req_we     = we;
    a_req_funct3 = f3;
    a_req_addr   = addr;
    a_req_wdata  = wd;
    a_rsp_ready  = (hold == 0);
    sb_q.push_back('{err: exp_err, rdata: exp_rd});
    @(posedge clk); #1;
    a_req_valid  = 1'b0;
    a_req_funct3 = 3'b111;
    a_req_addr   = 16'hFFFF;
    a_req_wdata  = 32'h0;
    lat = 1;
    wen_cycles = 0;
    while (!a_rsp_valid && lat < 40) begin
      if (a_dm_w_en != 4'b0000) begin
        wen_cycles++;
        check({tag, ".w_en"}, 32'(a_dm_w_en), 32'(exp_wen));
        check({tag, ".dm_data"}, a_dm_data, wd);
      end
      check({tag, ".dm_address"}, 32'(a_dm_address), 32'(addr));
      check({tag, ".req_ready_busy"}, 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".w_en_cycles"}, 32'(wen_cycles), (we && !exp_err) ? 32'd1 : 32'd0);
    held_rd  = a_rsp_rdata;
    held_err = a_rsp_err;
    for (int i = 0; i < hold; i++) begin
      check({tag, ".hold_valid"}, 32'(a_rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, a_rsp_rdata, held_rd);
      check({tag, ".hold_err"}, 32'(a_rsp_err), 32'(held_err));
      check({tag, ".hold_req_ready"}, 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1;
    check({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".rsp_valid"}, 32'(a_rsp_valid), 32'd1);
      check({tag, ".rsp_rdata"}, a_rsp_rdata, e.rdata);
      check({tag, ".rsp_err"}, 32'(a_rsp_err), 32'(e.err));
      check({tag, ".resp_w_en"}, 32'(a_dm_w_en), 32'd0);
    end
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check({tag, ".rsp_valid_after"}, 32'(a_rsp_valid), 32'd0);
    check({tag, ".req_ready_after"}, 32'(a_req_ready), 32'd1);
  endtask

  // Load on instance b (WAIT_CYCLES=2): latency and address stability.
  task automatic run_b(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                       input logic [31:0] exp_rd, input int exp_lat);
    int   lat;
    exp_t e;
    b_req_valid  = 1'b1;
    b_req_we     = 1'b0;
    b_req_funct3 = f3;
    b_req_addr   = addr;
    sb_q.push_back('{err: 1'b0, rdata: exp_rd});
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    b_req_addr  = 16'h0000;
    lat = 1;
    while (!b_rsp_valid && lat < 40) begin
      check({tag, ".dm_address"}, 32'(b_dm_address), 32'(addr));
      check({tag, ".w_en"}, 32'(b_dm_w_en), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    b_rsp_ready = 1'b1;
    check({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".rsp_rdata"}, b_rsp_rdata, e.rdata);
      check({tag, ".rsp_err"}, 32'(b_rsp_err), 32'(e.err));
    end
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    check({tag, ".rsp_valid_after"}, 32'(b_rsp_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++) mem_a[i] = init_byte(16'(i));
    a_mem_drive  = 1'b0;
    a_req_valid  = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'b000;
    a_req_addr   = 16'h0; a_req_wdata = 32'h0; a_rsp_ready = 1'b0;
    b_req_valid  = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b000;
    b_req_addr   = 16'h0; b_req_wdata = 32'h0; b_rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset.req_ready", 32'(a_req_ready), 32'd1);
    check("reset.rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("reset.rsp_rdata", a_rsp_rdata, 32'd0);
    check("reset.rsp_err", 32'(a_rsp_err), 32'd0);
    check("reset.w_en", 32'(a_dm_w_en), 32'd0);
    check("reset.dm_address", 32'(a_dm_address), 32'd0);
    check("reset.dm_data_released", a_dm_data, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    a_mem_drive = 1'b1;
    @(posedge clk); #1;

    run_a("sw_100",   1'b1, 3'b010, 16'h0100, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 2, 0);
    run_a("lw_100",   1'b0, 3'b010, 16'h0100, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 2, 0);
    run_a("sb_103",   1'b1, 3'b000, 16'h0103, 32'h00000080, 32'h0,        1'b0, 4'b0001, 2, 0);
    run_a("lb_103",   1'b0, 3'b000, 16'h0103, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 2, 0);
    run_a("lbu_103",  1'b0, 3'b100, 16'h0103, 32'h0,        32'h00000080, 1'b0, 4'b0000, 2, 0);
    run_a("lw_100b",  1'b0, 3'b010, 16'h0100, 32'h0,        32'h80ADBEEF, 1'b0, 4'b0000, 2, 0);
    run_a("sh_110",   1'b1, 3'b001, 16'h0110, 32'h5555F00D, 32'h0,        1'b0, 4'b0011, 2, 0);
    run_a("lh_110",   1'b0, 3'b001, 16'h0110, 32'h0,        32'hFFFFF00D, 1'b0, 4'b0000, 2, 0);
    run_a("lhu_110",  1'b0, 3'b101, 16'h0110, 32'h0,        32'h0000F00D, 1'b0, 4'b0000, 2, 0);
    run_a("lw_112",   1'b0, 3'b010, 16'h0110, 32'h0,
          {init_byte(16'h0113), init_byte(16'h0112), 16'hF00D},    1'b0, 4'b0000, 2, 0);
    run_a("lh_101",   1'b0, 3'b001, 16'h0101, 32'h0,        32'h0,        1'b1, 4'b0000, 1, 0);
    run_a("f3_011",   1'b0, 3'b011, 16'h0100, 32'h0,        32'h0,        1'b1, 4'b0000, 1, 0);
    run_a("sbu_st",   1'b1, 3'b100, 16'h0100, 32'h00000011, 32'h0,        1'b1, 4'b0000, 1, 0);
    run_a("lw_102",   1'b0, 3'b010, 16'h0102, 32'h0,        32'h0,        1'b1, 4'b0000, 1, 0);
    run_a("lw_hold",  1'b0, 3'b010, 16'h0100, 32'h0,        32'h80ADBEEF, 1'b0, 4'b0000, 2, 5);

    run_b("b_lw_040", 3'b010, 16'h0040, init_word(16'h0040), 4);
    run_b("b_lh_080", 3'b001, 16'h0080, {16'hFFFF, init_byte(16'h0081), init_byte(16'h0080)}, 4);

    // Reset during the ACCESS cycle of a store: the write must be cancelled.
    a_mem_drive  = 1'b0;
    a_req_valid  = 1'b1;
    a_req_we     = 1'b1;
    a_req_funct3 = 3'b010;
    a_req_addr   = 16'h0200;
    a_req_wdata  = 32'h12345678;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("rst_mid.w_en_before", 32'(a_dm_w_en), 32'hF);
    rst_n = 1'b0;
    #1;
    check("rst_mid.w_en", 32'(a_dm_w_en), 32'd0);
    check("rst_mid.dm_data_released", a_dm_data, 32'hFFFF_FFFF);
    check("rst_mid.rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_mid.req_ready", 32'(a_req_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    a_mem_drive = 1'b1;
    @(posedge clk); #1;
    run_a("lw_200",   1'b0, 3'b010, 16'h0200, 32'h0,        init_word(16'h0200), 1'b0, 4'b0000, 2, 0);

    check("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
